alu_arbiter: RTL and testbench

Shares the single combinational `alu` between two requesters, A (instruction datapath) and B (auxiliary/debug engine), at up to one operation per clock. Arbitration is round-robin with valid/ready handshakes on the request side, and each requester has its own registered result slot with valid/ready backpressure. The block drives the ALU's `op`/`r0`/`r1` inputs and captures `res`, so it sits between the requesters and the `alu` instance.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Lets two requesters share one combinational ALU, at most one operation
// per clock. A is the instruction datapath and B is the auxiliary/debug
// engine. The arbiter drives the external ALU inputs and captures its
// result into a registered result slot for the requester that won.
//
// Ports
//   clock, reset                   clock; synchronous active-high reset
//   a_valid / a_ready              A request handshake (a_ready = grant)
//   a_op, a_r0, a_r1               A op code and operands
//   a_res_valid / a_res_ready      A result slot handshake
//   a_res                          A result slot contents
//   b_*                            same set of ports for requester B
//   alu_op, alu_r0, alu_r1         driven to the shared alu instance
//   alu_res                        result returned by the alu instance
//
// State
//   last_grant | meaning
//   -----------+------------------------------------------------
//   1'b0       | A won the most recent grant, so B wins the next tie
//   1'b1       | B won the most recent grant (also the reset value),
//              | so A wins the next tie

module alu_arbiter #(
   parameter int WORD_SIZE = 18
) (
   input  logic                 clock,
   input  logic                 reset,

   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [3:0]           a_op,
   input  logic [WORD_SIZE-1:0] a_r0,
   input  logic [WORD_SIZE-1:0] a_r1,
   output logic                 a_res_valid,
   input  logic                 a_res_ready,
   output logic [WORD_SIZE-1:0] a_res,

   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [3:0]           b_op,
   input  logic [WORD_SIZE-1:0] b_r0,
   input  logic [WORD_SIZE-1:0] b_r1,
   output logic                 b_res_valid,
   input  logic                 b_res_ready,
   output logic [WORD_SIZE-1:0] b_res,

   output logic [3:0]           alu_op,
   output logic [WORD_SIZE-1:0] alu_r0,
   output logic [WORD_SIZE-1:0] alu_r1,
   input  logic [WORD_SIZE-1:0] alu_res
);

   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;

   logic last_grant;
   logic elig_a;
   logic elig_b;
   logic grant_a;
   logic grant_b;

   // A slot that is draining this cycle can take a new result at the same
   // edge, which keeps a streaming requester free of bubbles.
   assign elig_a = a_valid && (!a_res_valid || a_res_ready);
   assign elig_b = b_valid && (!b_res_valid || b_res_ready);

   // On a tie, the requester that did not win most recently goes first.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (elig_a && elig_b) begin
         grant_a = (last_grant == LAST_B);
         grant_b = (last_grant == LAST_A);
      end else begin
         grant_a = elig_a;
         grant_b = elig_b;
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // The ALU sees zeros when idle so its inputs do not toggle for nothing.
   always_comb begin
      alu_op = 4'd0;
      alu_r0 = '0;
      alu_r1 = '0;
      if (grant_a) begin
         alu_op = a_op;
         alu_r0 = a_r0;
         alu_r1 = a_r1;
      end else if (grant_b) begin
         alu_op = b_op;
         alu_r0 = b_r0;
         alu_r1 = b_r1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant <= LAST_B;
      end else if (grant_a) begin
         last_grant <= LAST_A;
      end else if (grant_b) begin
         last_grant <= LAST_B;
      end
   end

   // Result slot A. A grant has priority over a consume, so a slot that
   // drains while being refilled stays valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_res_valid <= 1'b0;
         a_res       <= '0;
      end else if (grant_a) begin
         a_res_valid <= 1'b1;
         a_res       <= alu_res;
      end else if (a_res_ready) begin
         a_res_valid <= 1'b0;
      end
   end

   // Result slot B, same rules as slot A.
   always_ff @(posedge clock) begin
      if (reset) begin
         b_res_valid <= 1'b0;
         b_res       <= '0;
      end else if (grant_b) begin
         b_res_valid <= 1'b1;
         b_res       <= alu_res;
      end else if (b_res_ready) begin
         b_res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   localparam int W = 18;

   logic         clock;
   logic         reset;
   logic         a_valid, a_ready, a_res_valid, a_res_ready;
   logic [3:0]   a_op;
   logic [W-1:0] a_r0, a_r1, a_res;
   logic         b_valid, b_ready, b_res_valid, b_res_ready;
   logic [3:0]   b_op;
   logic [W-1:0] b_r0, b_r1, b_res;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_r0, alu_r1, alu_res;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   logic         exp_av, exp_bv;
   logic [W-1:0] exp_ares, exp_bres;

   alu_arbiter #(.WORD_SIZE(W)) dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_r0(a_r0), .a_r1(a_r1),
      .a_res_valid(a_res_valid), .a_res_ready(a_res_ready), .a_res(a_res),
      .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_r0(b_r0), .b_r1(b_r1),
      .b_res_valid(b_res_valid), .b_res_ready(b_res_ready), .b_res(b_res),
      .alu_op(alu_op), .alu_r0(alu_r0), .alu_r1(alu_r1), .alu_res(alu_res)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [W-1:0] alu_f(input logic [3:0] op,
                                           input logic [W-1:0] r0,
                                           input logic [W-1:0] r1);
      case (op)
         4'd0: return r0;
         4'd1: return r1;
         4'd2: return r0 + r1;
         4'd3: return r0 - r1;
         4'd4: return r0 & r1;
         4'd5: return r0 | r1;
         4'd6: return r0 ^ r1;
         4'd7: return ~r1;
         default: return '0;
      endcase
   endfunction

   // Stand-in for the external alu instance.
   always_comb alu_res = alu_f(alu_op, alu_r0, alu_r1);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus. ga/gb are the hand-derived expected grants.
   task automatic step(input logic rst,
                       input logic av, input logic [3:0] aop, input logic [W-1:0] ar0,
                       input logic [W-1:0] ar1, input logic arr,
                       input logic bv, input logic [3:0] bop, input logic [W-1:0] br0,
                       input logic [W-1:0] br1, input logic brr,
                       input logic ga, input logic gb, input string tag);
      logic [3:0]   eop;
      logic [W-1:0] er0, er1;
      @(negedge clock);
      reset = rst;
      a_valid = av; a_op = aop; a_r0 = ar0; a_r1 = ar1; a_res_ready = arr;
      b_valid = bv; b_op = bop; b_r0 = br0; b_r1 = br1; b_res_ready = brr;
      eop = 4'd0; er0 = '0; er1 = '0;
      if (ga) begin
         eop = aop; er0 = ar0; er1 = ar1;
         qa.push_back(alu_f(aop, ar0, ar1));
      end else if (gb) begin
         eop = bop; er0 = br0; er1 = br1;
         qb.push_back(alu_f(bop, br0, br1));
      end
      #1;
      chk({tag, ".a_ready"}, 32'(a_ready), 32'(ga));
      chk({tag, ".b_ready"}, 32'(b_ready), 32'(gb));
      chk({tag, ".alu_op"}, 32'(alu_op), 32'(eop));
      chk({tag, ".alu_r0"}, 32'(alu_r0), 32'(er0));
      chk({tag, ".alu_r1"}, 32'(alu_r1), 32'(er1));
      @(posedge clock);
      #1;
      if (rst) begin
         exp_av = 1'b0; exp_bv = 1'b0; exp_ares = '0; exp_bres = '0;
         qa.delete(); qb.delete();
      end else begin
         if (ga) begin
            exp_av = 1'b1;
            exp_ares = qa.pop_front();
         end else if (arr) exp_av = 1'b0;
         if (gb) begin
            exp_bv = 1'b1;
            exp_bres = qb.pop_front();
         end else if (brr) exp_bv = 1'b0;
      end
      chk({tag, ".a_res_valid"}, 32'(a_res_valid), 32'(exp_av));
      chk({tag, ".b_res_valid"}, 32'(b_res_valid), 32'(exp_bv));
      chk({tag, ".a_res"}, 32'(a_res), 32'(exp_ares));
      chk({tag, ".b_res"}, 32'(b_res), 32'(exp_bres));
   endtask

   initial begin
      reset = 1'b1;
      a_valid = 0; a_op = 0; a_r0 = 0; a_r1 = 0; a_res_ready = 0;
      b_valid = 0; b_op = 0; b_r0 = 0; b_r1 = 0; b_res_ready = 0;
      exp_av = 0; exp_bv = 0; exp_ares = 0; exp_bres = 0;

      // reset state
      step(1, 0,0,0,0,1, 0,0,0,0,1, 0,0, "rst0");
      step(1, 0,0,0,0,1, 0,0,0,0,1, 0,0, "rst1");

      // A alone: ADD 5+3
      step(0, 1,4'd2,18'd5,18'd3,1, 0,0,0,0,1, 1,0, "add");

      // both valid, both consumers ready: last grant was A, so B,A,B,A
      step(0, 1,4'd3,18'd0,18'd1,1, 1,4'd6,18'h3FFFF,18'h00FFF,1, 0,1, "alt0");
      step(0, 1,4'd3,18'd0,18'd1,1, 1,4'd6,18'h3FFFF,18'h00FFF,1, 1,0, "alt1");
      step(0, 1,4'd3,18'd0,18'd1,1, 1,4'd6,18'h3FFFF,18'h00FFF,1, 0,1, "alt2");
      step(0, 1,4'd3,18'd0,18'd1,1, 1,4'd6,18'h3FFFF,18'h00FFF,1, 1,0, "alt3");
      step(0, 0,0,0,0,1, 0,0,0,0,1, 0,0, "drain");

      // backpressure: A result 8 pending, A stalled for 3 cycles while B runs
      step(0, 1,4'd2,18'd5,18'd3,0, 0,0,0,0,1, 1,0, "bp_fill");
      step(0, 1,4'd2,18'd10,18'd20,0, 1,4'd4,18'h0F0F0,18'h3FF00,1, 0,1, "bp_stall0");
      step(0, 1,4'd2,18'd10,18'd20,0, 1,4'd5,18'h00011,18'h00100,1, 0,1, "bp_stall1");
      step(0, 1,4'd2,18'd10,18'd20,0, 1,4'd1,18'h00001,18'h12345,1, 0,1, "bp_stall2");
      // consumer ready again: A wins the tie, refill without a bubble
      step(0, 1,4'd2,18'd10,18'd20,1, 1,4'd1,18'h00001,18'h12345,1, 1,0, "bp_release");
      step(0, 0,0,0,0,1, 0,0,0,0,1, 0,0, "bp_drain");

      // idle, then tie goes to B (A won last)
      step(0, 0,4'd5,18'h1,18'h2,1, 0,4'd6,18'h3,18'h4,1, 0,0, "idle");
      step(0, 1,4'd0,18'h00ABC,18'h0,1, 1,4'd0,18'h00DEF,18'h0,1, 0,1, "idle_tie");

      // op coverage on B
      step(0, 0,0,0,0,1, 1,4'd7,18'h0,18'h00001,1, 0,1, "op_not");
      step(0, 0,0,0,0,1, 1,4'd4,18'h2AAAA,18'h3FFFF,1, 0,1, "op_and");
      step(0, 0,0,0,0,1, 1,4'd9,18'h12345,18'h00F00,1, 0,1, "op_9");
      step(0, 0,0,0,0,1, 1,4'd2,18'h3FFFF,18'h00001,1, 0,1, "op_wrap");
      chk("op_wrap.value", 32'(b_res), 32'd0);

      // leave a pending A result, then reset while B is granted
      step(0, 1,4'd0,18'h00777,18'h0,0, 0,0,0,0,1, 1,0, "pre_rst");
      step(1, 0,0,0,0,0, 1,4'd2,18'd1,18'd2,1, 0,1, "mid_rst");
      step(0, 1,4'd2,18'd7,18'd7,1, 1,4'd3,18'd9,18'd4,1, 1,0, "post_rst_tie");
      step(0, 0,0,0,0,1, 1,4'd3,18'd9,18'd4,1, 0,1, "post_rst_b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
